// File: rtl/tl_grant_pkg.sv
// Shared Grant-channel definitions for the grant locking router.
// Optional build macro used by the router: TL_BEAT_CHECK_EN.
package tl_grant_pkg;

  localparam int DATA_W_DEFAULT  = 128;
  localparam int XACT_W_DEFAULT  = 6;
  localparam int MXACT_W_DEFAULT = 4;
  localparam int BEATS_DEFAULT   = 4;

  // Builtin g_type encodings
  localparam logic [2:0] GNT_VOLUNTARY_ACK = 3'b000;
  localparam logic [2:0] GNT_PREFETCH_ACK  = 3'b001;
  localparam logic [2:0] GNT_PUT_ACK       = 3'b011;
  localparam logic [2:0] GNT_DATA_BEAT     = 3'b100;
  localparam logic [2:0] GNT_DATA_BLOCK    = 3'b101;

  // Route-lock FSM encoding
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Grant payload at the default widths (client_id is consumed by routing)
  typedef struct packed {
    logic [XACT_W_DEFAULT-1:0]         client_xact_id;
    logic [MXACT_W_DEFAULT-1:0]        manager_xact_id;
    logic [$clog2(BEATS_DEFAULT)-1:0]  addr_beat;
    logic                              is_builtin_type;
    logic [2:0]                        g_type;
    logic [DATA_W_DEFAULT-1:0]         data;
  } grant_bits_t;

  function automatic logic has_multibeat_data(input logic is_builtin, input logic [2:0] g_type);
    return (is_builtin && g_type == GNT_DATA_BLOCK) || (!is_builtin && !g_type[2]);
  endfunction

endpackage

// File: rtl/grant_out_buffer.sv
// One-entry valid/ready register slice whose single entry is visible only to
// the client named by its destination tag.
module grant_out_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_dst,
  input  logic [W-1:0] in_bits,
  output logic [2:0]   out_valid,
  input  logic [2:0]   out_ready,
  output logic [W-1:0] out_bits
);

  logic         buf_valid;
  logic [1:0]   buf_dst;
  logic [W-1:0] buf_bits;
  logic         dst_ready;
  logic         load;

  // NOTE: default assigned first so every path drives dst_ready and no latch is inferred.
  always_comb begin
    dst_ready = 1'b0;
    case (buf_dst)
      2'd0:    dst_ready = out_ready[0];
      2'd1:    dst_ready = out_ready[1];
      2'd2:    dst_ready = out_ready[2];
      default: dst_ready = 1'b0;
    endcase
  end

  // Ready while empty or while the occupant drains this cycle: full throughput.
  assign in_ready = !buf_valid || dst_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_dst   <= 2'd0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_dst   <= in_dst;
    end else if (buf_valid && dst_ready) begin
      buf_valid <= 1'b0;
    end
  end

  // NOTE: payload is not reset; it is qualified by buf_valid, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (load) buf_bits <= in_bits;
  end

  assign out_valid[0] = buf_valid && (buf_dst == 2'd0);
  assign out_valid[1] = buf_valid && (buf_dst == 2'd1);
  assign out_valid[2] = buf_valid && (buf_dst == 2'd2);
  assign out_bits     = buf_bits;

endmodule

// File: rtl/grant_locking_router.sv
// Routes a manager Grant stream to three clients, locking the route for the
// duration of a multi-beat data grant. Optional macro: TL_BEAT_CHECK_EN.
module grant_locking_router
  import tl_grant_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int XACT_W  = 6,
  parameter int MXACT_W = 4,
  parameter int BEATS   = 4,
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [1:0]         io_in_bits_client_id,
  input  logic [XACT_W-1:0]  io_in_bits_client_xact_id,
  input  logic [MXACT_W-1:0] io_in_bits_manager_xact_id,
  input  logic [BEAT_W-1:0]  io_in_bits_addr_beat,
  input  logic               io_in_bits_is_builtin_type,
  input  logic [2:0]         io_in_bits_g_type,
  input  logic [DATA_W-1:0]  io_in_bits_data,
  output logic               io_out_0_valid,
  input  logic               io_out_0_ready,
  output logic [XACT_W-1:0]  io_out_0_bits_client_xact_id,
  output logic [MXACT_W-1:0] io_out_0_bits_manager_xact_id,
  output logic [BEAT_W-1:0]  io_out_0_bits_addr_beat,
  output logic               io_out_0_bits_is_builtin_type,
  output logic [2:0]         io_out_0_bits_g_type,
  output logic [DATA_W-1:0]  io_out_0_bits_data,
  output logic               io_out_1_valid,
  input  logic               io_out_1_ready,
  output logic [XACT_W-1:0]  io_out_1_bits_client_xact_id,
  output logic [MXACT_W-1:0] io_out_1_bits_manager_xact_id,
  output logic [BEAT_W-1:0]  io_out_1_bits_addr_beat,
  output logic               io_out_1_bits_is_builtin_type,
  output logic [2:0]         io_out_1_bits_g_type,
  output logic [DATA_W-1:0]  io_out_1_bits_data,
  output logic               io_out_2_valid,
  input  logic               io_out_2_ready,
  output logic [XACT_W-1:0]  io_out_2_bits_client_xact_id,
  output logic [MXACT_W-1:0] io_out_2_bits_manager_xact_id,
  output logic [BEAT_W-1:0]  io_out_2_bits_addr_beat,
  output logic               io_out_2_bits_is_builtin_type,
  output logic [2:0]         io_out_2_bits_g_type,
  output logic [DATA_W-1:0]  io_out_2_bits_data,
  output logic               io_err,
  output logic               io_locked
);

  localparam int BW = XACT_W + MXACT_W + BEAT_W + 1 + 3 + DATA_W;

  logic [0:0]        state;
  logic [1:0]        lock_idx;
  logic [BEAT_W-1:0] beat_cnt;
  logic              err_q;

  logic              locked;
  logic              multibeat;
  logic              accept;
  logic              drop;
  logic              id_err;
  logic              beat_err;
  logic              err_next;
  logic [1:0]        dst;
  logic [BW-1:0]     in_bits;
  logic [BW-1:0]     out_bits;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;

  assign locked    = (state == LOCKED);
  assign multibeat = has_multibeat_data(io_in_bits_is_builtin_type, io_in_bits_g_type);
  assign accept    = io_in_valid && io_in_ready;
  assign dst       = locked ? lock_idx : io_in_bits_client_id;

  // Client 3 does not exist: such a beat is consumed but never buffered.
  assign drop      = !locked && (io_in_bits_client_id == 2'd3);
  assign id_err    = locked && (io_in_bits_client_id != lock_idx);

`ifdef TL_BEAT_CHECK_EN
  assign beat_err  = accept && (io_in_bits_addr_beat != (locked ? beat_cnt : '0));
`else
  assign beat_err  = 1'b0;
`endif

  assign err_next  = (accept && (drop || id_err)) || beat_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lock_idx <= 2'd0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_next;
      if (accept) begin
        if (!locked) begin
          if (multibeat && !drop) begin
            state    <= LOCKED;
            lock_idx <= io_in_bits_client_id;
            beat_cnt <= BEAT_W'(1);
          end
        end else begin
          // BEATS is a power of two, so the increment wraps to 0 on the last beat.
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == '1) state <= IDLE;
        end
      end
    end
  end

  assign in_bits = {io_in_bits_client_xact_id, io_in_bits_manager_xact_id,
                    io_in_bits_addr_beat, io_in_bits_is_builtin_type,
                    io_in_bits_g_type, io_in_bits_data};

  assign out_ready = {io_out_2_ready, io_out_1_ready, io_out_0_ready};

  grant_out_buffer #(.W(BW)) u_out_buffer (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (io_in_valid && !drop),
    .in_ready  (io_in_ready),
    .in_dst    (dst),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits)
  );

  assign io_out_0_valid = out_valid[0];
  assign io_out_1_valid = out_valid[1];
  assign io_out_2_valid = out_valid[2];

  assign {io_out_0_bits_client_xact_id, io_out_0_bits_manager_xact_id,
          io_out_0_bits_addr_beat, io_out_0_bits_is_builtin_type,
          io_out_0_bits_g_type, io_out_0_bits_data} = out_bits;
  assign {io_out_1_bits_client_xact_id, io_out_1_bits_manager_xact_id,
          io_out_1_bits_addr_beat, io_out_1_bits_is_builtin_type,
          io_out_1_bits_g_type, io_out_1_bits_data} = out_bits;
  assign {io_out_2_bits_client_xact_id, io_out_2_bits_manager_xact_id,
          io_out_2_bits_addr_beat, io_out_2_bits_is_builtin_type,
          io_out_2_bits_g_type, io_out_2_bits_data} = out_bits;

  assign io_err    = err_q;
  assign io_locked = locked;

endmodule

// File: doc/grant_locking_router.md
Name: grant_locking_router

Overview:
- Response-side counterpart of the 3-client locking Acquire arbiter.
- Takes the single manager-facing Grant stream and routes each beat to one of three client ports, selected by a destination field.
- A multi-beat data grant locks the route to one client until its last beat is accepted.
- One-entry registered output stage: routing is pipelined and out_valid/out_bits do not depend combinationally on in_valid/in_bits.

Parameters:
DATA_W, 128, grant data width
XACT_W, 6, client_xact_id width
MXACT_W, 4, manager_xact_id width
BEATS, 4, beats per multi-beat grant (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
io_in_valid  in  1  grant beat valid
io_in_ready  out  1  grant beat accepted when valid&ready
io_in_bits_client_id  in  2  destination client 0..2; 3 illegal
io_in_bits_client_xact_id  in  XACT_W  client transaction id
io_in_bits_manager_xact_id  in  MXACT_W  manager transaction id
io_in_bits_addr_beat  in  log2(BEATS)  beat index
io_in_bits_is_builtin_type  in  1  builtin grant flag
io_in_bits_g_type  in  3  grant type
io_in_bits_data  in  DATA_W  beat data
io_out_<k>_valid  out  1  k=0,1,2: beat valid for client k
io_out_<k>_ready  in  1  client k accepts
io_out_<k>_bits_*  out  as input  registered copy of in bits (client_id omitted)
io_err  out  1  one-cycle pulse on protocol error
io_locked  out  1  route lock active

Behaviour:
- Clock/reset: clk only; reset synchronous, active-high, highest priority.
- Reset values: buffer empty; all io_out_<k>_valid=0; io_locked=0; beat counter 0; lock index 0; io_err=0; io_out bits undefined/don't-care.
- Multi-beat test (package function): (is_builtin_type && g_type==GNT_DATA_BLOCK=3'b101) || (!is_builtin_type && g_type[2]==0).
- Output buffer:
  - Holds one beat plus a 2-bit destination index; valid only to that client.
  - io_out_<k>_valid = buf_valid && buf_dst==k.
  - io_in_ready = !buf_valid || io_out_<buf_dst>_ready, giving full throughput.
  - Latency: accepted beat appears on outputs the next cycle.
  - Drain and refill in the same cycle are allowed.
  - Holds stable while valid&&!ready.
- Destination:
  - Unlocked: dst = io_in_bits_client_id.
  - Locked: dst = lock index, regardless of client_id.
- FSM IDLE/LOCKED:
  - IDLE: accepting a multi-beat beat -> LOCKED, lock index=dst, counter=1.
  - IDLE: accepting a single-beat beat -> stays IDLE.
  - LOCKED: each accepted beat increments the counter (mod BEATS).
  - LOCKED: accepting the beat with counter==BEATS-1 -> IDLE, counter wraps to 0.
  - io_locked = (state==LOCKED).
- Errors (io_err pulses the cycle after the offending accept):
  - Unlocked beat with client_id==3: consumed, dropped (no buffer load), no lock.
  - LOCKED beat whose client_id != lock index: still forwarded to the lock index.
- Simultaneous events: buffer drain, input accept and lock release in one cycle are all legal.
- Reset mid-burst: lock, counter and buffer cleared; remaining beats are treated as new transfers.

Optional Feature:
- Macro: TL_BEAT_CHECK_EN.
- Defined: on each accepted beat, compare io_in_bits_addr_beat with the expected beat (0 in IDLE, counter in LOCKED); mismatch pulses io_err. Routing and data are unaffected.
- Undefined: addr_beat is passed through unchecked and cannot raise io_err.

Decomposition:
- Package tl_grant_pkg:
  - GNT_DATA_BLOCK and other g_type constants.
  - BEATS default.
  - grant_bits_t struct.
  - function has_multibeat_data(is_builtin, g_type).
  - state enum {IDLE, LOCKED}.
- Sub-module grant_out_buffer: one-entry valid/ready register slice with destination tag. Instantiated once.

Test Plan:
- Single-beat putAck (builtin, g_type=3'b011) to client 2, all readys=1 -> io_out_2_valid one cycle later, bits equal, io_locked stays 0.
- 4-beat getDataBlock to client 1, beats 1-3 carrying client_id=0 -> all 4 beats on out_1, io_err pulses 3 times, io_locked high until the 4th accept.
- Back-to-back: out_0_ready low for 3 cycles -> buffer holds, io_in_ready=0, no beat lost/duplicated; with ready=1, one beat per cycle.
- client_id=3 while unlocked, data 0xDEAD -> accepted, no out valid, io_err=1 next cycle.
- Reset asserted after beat 2 of a burst -> next cycle io_locked=0, all out valid 0; a new single-beat grant to client 0 routes normally.
- TL_BEAT_CHECK_EN defined: burst with addr_beat sequence 0,1,3,3 -> io_err pulses once (3rd beat); macro undefined -> no pulse.
